eprobe_led_serializer: RTL and testbench

- Downstream stage of the E-probe LED command controller.
- Captures each parallel LED word {probe, addr, pix, vled, en_led} on a rising edge of load and buffers it in a small FIFO.
- Shifts each word MSB-first to the probe ASIC over a 3-wire interface (sclk, sdata, slatch).
- The upstream controller has no backpressure, so overflow is counted and flagged, never stalled.

---
 rtl/eprobe_pkg.sv | 20 ++
 rtl/eprobe_frame_fifo.sv | 55 +++++
 rtl/eprobe_led_serializer.sv | 207 ++++++++++++++++++++
 tb/tb_eprobe_led_serializer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/eprobe_pkg.sv
// Shared frame layout, FSM encoding and status widths for the E-probe LED serializer.
package eprobe_pkg;

    localparam int FRAME_W    = 14;
    localparam int BIT_CNT_W  = $clog2(FRAME_W);
    localparam int DROP_CNT_W = 16;

    localparam int PROBE_MSB = 13;
    localparam int ADDR_MSB  = 11;
    localparam int PIX_MSB   = 5;
    localparam int VLED_MSB  = 3;
    localparam int EN_BIT    = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LATCH = 2'd2
    } state_t;

endpackage

// File: rtl/eprobe_frame_fifo.sv
// First-word fall-through FIFO holding captured LED frames until the serializer can send them.
module eprobe_frame_fifo
    import eprobe_pkg::*;
#(
    parameter int FIFO_AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [FRAME_W-1:0] din,
    output logic [FRAME_W-1:0] dout,
    output logic [FIFO_AW:0]   level,
    output logic               full,
    output logic               empty
);

    localparam int DEPTH   = 2 ** FIFO_AW;
    localparam int LEVEL_W = FIFO_AW + 1;

    logic [FRAME_W-1:0] r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_level == '0);
    assign full      = (r_level == LEVEL_W'(DEPTH));
    assign w_do_pop  = pop & ~empty;
    // A pop frees the head slot this cycle, so a full FIFO can still take a word.
    assign w_do_push = push & (~full | w_do_pop);
    assign dout      = r_mem[r_rd_ptr];
    assign level     = r_level;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
            else if (!w_do_push && w_do_pop) r_level <= r_level - 1'b1;
        end
    end

endmodule

// File: rtl/eprobe_led_serializer.sv
// Captures LED command words on load edges, queues them, and shifts each out MSB-first
// over sclk/sdata followed by an slatch strobe; overflow is counted, never stalled.
module eprobe_led_serializer
    import eprobe_pkg::*;
#(
    parameter int CLK_DIV      = 4,
    parameter int FIFO_AW      = 4,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            probe,
    input  logic [5:0]            addr,
    input  logic [1:0]            pix,
    input  logic [2:0]            vled,
    input  logic                  en_led,
    input  logic                  load,
    input  logic                  clr_status,
    output logic                  sclk,
    output logic                  sdata,
    output logic                  slatch,
    output logic                  busy,
    output logic [FIFO_AW:0]      fifo_level,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_count
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [DIV_W-1:0]     DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0]     LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(FRAME_W - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_load_q;
    logic [FRAME_W-1:0]    r_shift;
    logic [FRAME_W-1:0]    w_shift_nxt;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [BIT_CNT_W-1:0]  w_bit_cnt_nxt;
    logic [DIV_W-1:0]      r_div_cnt;
    logic [DIV_W-1:0]      w_div_nxt;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [LAT_W-1:0]      w_lat_nxt;
    logic                  r_sclk, w_sclk_nxt;
    logic                  r_sdata, w_sdata_nxt;
    logic                  r_slatch, w_slatch_nxt;
    logic                  r_busy;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_count;

    logic [FRAME_W-1:0]    w_frame;
    logic [FRAME_W-1:0]    w_fifo_dout;
    logic [FIFO_AW:0]      w_level;
    logic [FIFO_AW:0]      w_level_nxt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_edge;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_drop;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        w_frame                       = '0;
        w_frame[PROBE_MSB -: 2]       = probe;
        w_frame[ADDR_MSB -: 6]        = addr;
        w_frame[PIX_MSB -: 2]         = pix;
        w_frame[VLED_MSB -: 3]        = vled;
        w_frame[EN_BIT]               = en_led;
    end

    assign w_edge = load & ~r_load_q;
    assign w_push = w_edge & (~w_full | w_pop);
    assign w_drop = w_edge & w_full & ~w_pop;

    eprobe_frame_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_frame),
        .dout  (w_fifo_dout),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_level_nxt = w_level;
        if (w_push && !w_pop)      w_level_nxt = w_level + 1'b1;
        else if (!w_push && w_pop) w_level_nxt = w_level - 1'b1;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_div_nxt     = r_div_cnt;
        w_lat_nxt     = r_lat_cnt;
        w_sclk_nxt    = r_sclk;
        w_sdata_nxt   = r_sdata;
        w_slatch_nxt  = r_slatch;
        w_pop         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop         = 1'b1;
                    w_shift_nxt   = w_fifo_dout;
                    w_sdata_nxt   = w_fifo_dout[FRAME_W-1];
                    w_bit_cnt_nxt = '0;
                    w_div_nxt     = '0;
                    w_sclk_nxt    = 1'b0;
                    w_state_nxt   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_div_cnt == DIV_LAST) begin
                    w_div_nxt = '0;
                    if (!r_sclk) begin
                        w_sclk_nxt = 1'b1;
                    end else begin
                        // Falling sclk: sdata moves to the next bit on the same edge.
                        w_sclk_nxt = 1'b0;
                        if (r_bit_cnt == BIT_LAST) begin
                            w_sdata_nxt  = 1'b0;
                            w_slatch_nxt = 1'b1;
                            w_lat_nxt    = '0;
                            w_state_nxt  = ST_LATCH;
                        end else begin
                            w_shift_nxt   = {r_shift[FRAME_W-2:0], 1'b0};
                            w_sdata_nxt   = r_shift[FRAME_W-2];
                            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
                        end
                    end
                end else begin
                    w_div_nxt = r_div_cnt + 1'b1;
                end
            end
            ST_LATCH: begin
                if (r_lat_cnt == LAT_LAST) begin
                    w_slatch_nxt = 1'b0;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_lat_nxt = r_lat_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        r_shift <= w_shift_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_load_q  <= 1'b0;
            r_bit_cnt <= '0;
            r_div_cnt <= '0;
            r_lat_cnt <= '0;
            r_sclk    <= 1'b0;
            r_sdata   <= 1'b0;
            r_slatch  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_load_q  <= load;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_div_cnt <= w_div_nxt;
            r_lat_cnt <= w_lat_nxt;
            r_sclk    <= w_sclk_nxt;
            r_sdata   <= w_sdata_nxt;
            r_slatch  <= w_slatch_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE) || (w_level_nxt != '0);
        end
    end

    // A drop coinciding with a clear survives as a single recorded drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else if (clr_status) begin
            r_overflow   <= w_drop;
            r_drop_count <= w_drop ? DROP_CNT_W'(1) : '0;
        end else if (w_drop) begin
            r_overflow   <= 1'b1;
            r_drop_count <= sat_inc(r_drop_count);
        end
    end

    assign sclk       = r_sclk;
    assign sdata      = r_sdata;
    assign slatch     = r_slatch;
    assign busy       = r_busy;
    assign fifo_level = w_level;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;

endmodule

// File: tb/tb_eprobe_led_serializer.sv
// Directed bench for eprobe_led_serializer: default instance plus a CLK_DIV=1/LATCH_CYCLES=1 instance.
module tb_eprobe_led_serializer;

    logic        clk, rst;
    logic [1:0]  probe, pix, probe2, pix2;
    logic [5:0]  addr, addr2;
    logic [2:0]  vled, vled2;
    logic        en_led, en_led2, load, load2, clr_status, clr2;
    logic        sclk, sdata, slatch, busy, overflow;
    logic        sclk2, sdata2, slatch2, busy2, overflow2;
    logic [4:0]  fifo_level, fifo_level2;
    logic [15:0] drop_count, drop_count2;

    eprobe_led_serializer #(.CLK_DIV(4), .FIFO_AW(4), .LATCH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .probe(probe), .addr(addr), .pix(pix), .vled(vled),
        .en_led(en_led), .load(load), .clr_status(clr_status), .sclk(sclk), .sdata(sdata),
        .slatch(slatch), .busy(busy), .fifo_level(fifo_level), .overflow(overflow),
        .drop_count(drop_count));

    eprobe_led_serializer #(.CLK_DIV(1), .FIFO_AW(4), .LATCH_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst), .probe(probe2), .addr(addr2), .pix(pix2), .vled(vled2),
        .en_led(en_led2), .load(load2), .clr_status(clr2), .sclk(sclk2), .sdata(sdata2),
        .slatch(slatch2), .busy(busy2), .fifo_level(fifo_level2), .overflow(overflow2),
        .drop_count(drop_count2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0, cyc = 0;
    logic        p_sclk, p_sdata, p_slatch, p_busy, p2_sclk, p2_slatch, p2_busy;
    logic [13:0] m_bits, m2_bits, f2_bits;
    int m_n, m_lat, m_start, m_edges, m_latch_rises, m_busy, m_peak, m_sd_err;
    int m2_n, m2_lat, m2_start, m2_busy, f2_n, f2_lat, f2_start, f2_cnt;
    logic [13:0] q_bits[$];
    int q_n[$], q_lat[$], q_start[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic sample();
        if (rst) begin
            m_n = 0; m_lat = 0; m2_n = 0; m2_lat = 0;
        end else begin
            if (sclk && !p_sclk) begin
                if (m_n == 0) m_start = cyc;
                m_bits = {m_bits[12:0], sdata};
                m_n++; m_edges++;
            end
            if (sclk && p_sclk && (sdata !== p_sdata)) m_sd_err++;
            if (slatch) m_lat++;
            if (slatch && !p_slatch) m_latch_rises++;
            if (!slatch && p_slatch) begin
                q_bits.push_back(m_bits); q_n.push_back(m_n);
                q_lat.push_back(m_lat); q_start.push_back(m_start);
                m_n = 0; m_lat = 0;
            end
            if (busy) m_busy++;
            if (int'(fifo_level) > m_peak) m_peak = int'(fifo_level);
            if (sclk2 && !p2_sclk) begin
                if (m2_n == 0) m2_start = cyc;
                m2_bits = {m2_bits[12:0], sdata2};
                m2_n++;
            end
            if (slatch2) m2_lat++;
            if (!slatch2 && p2_slatch) begin
                f2_bits = m2_bits; f2_n = m2_n; f2_lat = m2_lat; f2_start = m2_start; f2_cnt++;
                m2_n = 0; m2_lat = 0;
            end
            if (busy2) m2_busy++;
        end
        p_sclk = sclk; p_sdata = sdata; p_slatch = slatch; p_busy = busy;
        p2_sclk = sclk2; p2_slatch = slatch2; p2_busy = busy2;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic clear_mon();
        q_bits.delete(); q_n.delete(); q_lat.delete(); q_start.delete();
        m_n = 0; m_lat = 0; m_edges = 0; m_latch_rises = 0; m_busy = 0; m_peak = 0; m_sd_err = 0;
        m2_n = 0; m2_lat = 0; m2_busy = 0; f2_cnt = 0; f2_n = 0; f2_lat = 0;
    endtask

    task automatic set_word(input logic [13:0] w);
        {probe, addr, pix, vled, en_led} = w;
    endtask

    task automatic wait_done(input int which, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (which == 0 && m_busy > 0 && !p_busy) begin to = 1'b0; break; end
            if (which == 1 && m2_busy > 0 && !p2_busy) begin to = 1'b0; break; end
        end
    endtask

    initial begin
        int l0;
        bit to;
        logic [13:0] w;
        rst = 1'b1; load = 0; load2 = 0; clr_status = 0; clr2 = 0;
        set_word(14'h0); {probe2, addr2, pix2, vled2, en_led2} = 14'h0;
        p_sclk = 0; p_sdata = 0; p_slatch = 0; p_busy = 0; p2_sclk = 0; p2_slatch = 0; p2_busy = 0;
        m_bits = 0; m2_bits = 0; m_start = 0; m2_start = 0; f2_bits = 0; f2_start = 0;
        clear_mon();
        repeat (3) tick();
        chk("rst_sclk", sclk, 0);       chk("rst_sdata", sdata, 0);
        chk("rst_slatch", slatch, 0);   chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0); chk("rst_overflow", overflow, 0);
        chk("rst_drops", drop_count, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Scenario 1: single word
        clear_mon();
        l0 = cyc; set_word(14'b10_010101_01_101_1); load = 1; tick(); load = 0;
        wait_done(0, 300, to);
        chk("s1_timeout", to, 0);
        chk("s1_frames", q_bits.size(), 1);
        chk("s1_bits", q_bits[0], 14'b10_010101_01_101_1);
        chk("s1_nbits", q_n[0], 14);
        chk("s1_latch_len", q_lat[0], 2);
        chk("s1_first_rise", q_start[0] - l0, 6);
        chk("s1_busy_cycles", m_busy, 115);
        chk("s1_busy_end", busy, 0);

        // Scenario 2: load held high 10 cycles
        clear_mon();
        set_word(14'b01_101010_10_011_0); load = 1; repeat (10) tick(); load = 0;
        wait_done(0, 300, to);
        chk("s2_timeout", to, 0);
        chk("s2_frames", q_bits.size(), 1);
        chk("s2_bits", q_bits[0], 14'b01_101010_10_011_0);
        chk("s2_peak_level", m_peak, 1);
        chk("s2_drops", drop_count, 0);
        chk("s2_busy_cycles", m_busy, 115);

        // Scenario 3: 40 pulses into a 16-deep FIFO
        clear_mon();
        for (int i = 0; i < 40; i++) begin
            w = 14'(i * 37 + 5); set_word(w); load = 1; tick(); load = 0; tick();
        end
        chk("s3_overflow", overflow, 1);
        chk("s3_drops", drop_count, 23);
        chk("s3_peak_level", m_peak, 16);
        chk("s3_level", fifo_level, 16);
        wait_done(0, 17 * 115 + 100, to);
        chk("s3_timeout", to, 0);
        chk("s3_frames", q_bits.size(), 17);
        for (int k = 0; k < 17; k++) begin
            chk($sformatf("s3_word%0d", k), q_bits[k], 14'(k * 37 + 5));
            chk($sformatf("s3_latch%0d", k), q_lat[k], 2);
            if (k > 0) chk($sformatf("s3_spacing%0d", k), q_start[k] - q_start[k-1], 115);
        end
        chk("s3_sdata_stable", m_sd_err, 0);

        // Scenario 4: status clear, then clear coincident with a drop
        clr_status = 1; tick(); clr_status = 0;
        chk("s4_clr_overflow", overflow, 0);
        chk("s4_clr_drops", drop_count, 0);
        for (int i = 0; i < 17; i++) begin
            set_word(14'(i + 100)); load = 1; tick(); load = 0; tick();
        end
        chk("s4_full_level", fifo_level, 16);
        chk("s4_no_drop_yet", drop_count, 0);
        load = 1; clr_status = 1; tick(); load = 0; clr_status = 0;
        chk("s4_coinc_overflow", overflow, 1);
        chk("s4_coinc_drops", drop_count, 1);
        rst = 1; tick(); rst = 0;
        chk("s4_rst_overflow", overflow, 0);
        chk("s4_rst_drops", drop_count, 0);
        chk("s4_rst_level", fifo_level, 0);
        tick();

        // Scenario 5: reset during bit 7 with 3 words queued
        clear_mon();
        l0 = cyc;
        for (int i = 0; i < 4; i++) begin
            set_word((i == 0) ? 14'h3FFF : 14'(i * 11)); load = 1; tick(); load = 0; tick();
        end
        while (cyc < l0 + 54) tick();
        chk("s5_bits_before", m_n, 6);
        chk("s5_level_before", fifo_level, 3);
        chk("s5_sclk_before", sclk, 1);
        rst = 1; #1;
        chk("s5_rst_sclk", sclk, 0);
        chk("s5_rst_sdata", sdata, 0);
        chk("s5_rst_slatch", slatch, 0);
        chk("s5_rst_level", fifo_level, 0);
        chk("s5_rst_busy", busy, 0);
        repeat (2) tick();
        rst = 0;
        clear_mon();
        repeat (200) tick();
        chk("s5_no_sclk", m_edges, 0);
        chk("s5_no_slatch", m_latch_rises, 0);
        chk("s5_idle_busy", busy, 0);
        set_word(14'h1234); load = 1; tick(); load = 0;
        wait_done(0, 300, to);
        chk("s5_timeout", to, 0);
        chk("s5_frames", q_bits.size(), 1);
        chk("s5_bits", q_bits[0], 14'h1234);

        // Scenario 6: CLK_DIV=1, LATCH_CYCLES=1
        clear_mon();
        l0 = cyc; {probe2, addr2, pix2, vled2, en_led2} = 14'b10_010101_01_101_1; load2 = 1; tick(); load2 = 0;
        wait_done(1, 100, to);
        chk("s6_timeout", to, 0);
        chk("s6_frames", f2_cnt, 1);
        chk("s6_bits", f2_bits, 14'b10_010101_01_101_1);
        chk("s6_nbits", f2_n, 14);
        chk("s6_latch_len", f2_lat, 1);
        chk("s6_first_rise", f2_start - l0, 3);
        chk("s6_busy_cycles", m2_busy, 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
